// File: rtl/repadd_mul_param.sv
// repadd_mul_param
//   Multiplier by repeated addition. A and B arrive one after the other on
//   data_in; the larger magnitude is added into a 2*WIDTH accumulator as many
//   times as the smaller magnitude, and the sign is applied when the result
//   is registered.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start
//   LOAD_A | data_in holds A; captured, with signed_mode, on exit
//   LOAD_B | data_in holds B; magnitudes, sign, addend and counter formed
//   ADD    | one addition of M into P per cycle, counter C counts down
//   DONE   | product valid (done=1); start here chains a new operation
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request a new multiplication (honoured in IDLE/DONE only)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   data_in      operand bus, A then B
//   product      registered 2*WIDTH result
//   done         one-cycle result-valid strobe
//   busy         operation in progress

module repadd_mul_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     data_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] ADD    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]         state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic               smode_q,   smode_d;
    logic [2*WIDTH-1:0] p_q,       p_d;
    logic [WIDTH-1:0]   c_q,       c_d;
    logic [WIDTH-1:0]   m_q,       m_d;
    logic               sign_q,    sign_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] p_sum;

    // Negating the most negative value wraps back to the same bit pattern,
    // which read as unsigned is exactly 2^(WIDTH-1): no extra bit needed.
    assign mag_a = (smode_q && a_q[WIDTH-1])     ? (~a_q + ONE)     : a_q;
    assign mag_b = (smode_q && data_in[WIDTH-1]) ? (~data_in + ONE) : data_in;

    assign p_sum = p_q + {{WIDTH{1'b0}}, m_q};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        smode_d   = smode_q;
        p_d       = p_q;
        c_d       = c_q;
        m_d       = m_q;
        sign_d    = sign_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = start ? LOAD_A : IDLE;
            end
            LOAD_A: begin
                a_d     = data_in;
                smode_d = signed_mode;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                p_d    = '0;
                sign_d = smode_q & (a_q[WIDTH-1] ^ data_in[WIDTH-1]);
                // Count down the smaller magnitude to keep the loop short.
                if (mag_a >= mag_b) begin
                    m_d = mag_a;
                    c_d = mag_b;
                end else begin
                    m_d = mag_b;
                    c_d = mag_a;
                end
                if (mag_a == '0 || mag_b == '0) begin
                    // Zero result is written directly so no negative zero
                    // can come out of the sign step.
                    product_d = '0;
                    state_d   = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                p_d = p_sum;
                c_d = c_q - ONE;
                if (c_q == ONE) begin
                    product_d = sign_q ? (~p_sum + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_sum;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            smode_q   <= 1'b0;
            p_q       <= '0;
            c_q       <= '0;
            m_q       <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            smode_q   <= smode_d;
            p_q       <= p_d;
            c_q       <= c_d;
            m_q       <= m_d;
            sign_q    <= sign_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == ADD);

endmodule
